// File: rtl/cin_fifo.sv
// cin_fifo: confirm-button input FIFO with a tri-state bus read-out.
//
// A user value is pushed each time the (asynchronous) confirm button sees a
// new rising edge after synchronisation. The controller pops the head entry
// into an output register with cin_get and drives that register onto the
// shared bus with cin_write, zero- or sign-extended to BUS_W.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   bus            shared tri-state data bus (driven only while cin_write=1)
//   value          user value, sampled at the push edge
//   confirm_value  asynchronous confirm button, level
//   cin_get        pop head entry into the output register
//   cin_write      drive the output register onto bus
//   cin_clr        flush FIFO and clear overflow
//   cin_done       one-cycle pulse after each accepted push
//   cin_valid      FIFO non-empty
//   cin_full       FIFO holds DEPTH entries
//   cin_overflow   sticky: a push was dropped
//   cin_count      current occupancy 0..DEPTH
//
// Handshake: a push is accepted at an edge where the synchronised button
// rises and the FIFO is not full (or is popped at that same edge); a pop
// takes effect at an edge where cin_get=1 and cin_valid=1. Neither side
// waits: requests arriving while the other condition is false are ignored
// (pop) or dropped with cin_overflow set (push).
module cin_fifo #(
  parameter int DATA_W      = 16,
  parameter int BUS_W       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SIGN_EXT    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  wire  [BUS_W-1:0]         bus,
  input  logic [DATA_W-1:0]        value,
  input  logic                     confirm_value,
  input  logic                     cin_get,
  input  logic                     cin_write,
  input  logic                     cin_clr,
  output logic                     cin_done,
  output logic                     cin_valid,
  output logic                     cin_full,
  output logic                     cin_overflow,
  output logic [$clog2(DEPTH):0]   cin_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Elaboration-time parameter sanity.
  if (BUS_W < DATA_W) begin : g_bad_bus_w
    $error("cin_fifo: BUS_W must be >= DATA_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cin_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cin_fifo: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [DATA_W-1:0]      out_q;
  logic                   done_q;
  logic                   ovf_q;

  logic rise;
  logic full;
  logic valid;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign pop   = cin_get & valid;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign push_ok   = rise & (~full | pop);
  assign push_drop = rise & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // The synchroniser keeps running through cin_clr so a button edge in
      // flight is not lost or duplicated.
      sync_q <= {sync_q[SYNC_STAGES-2:0], confirm_value};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (cin_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        done_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        done_q <= push_ok;
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          out_q    <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        if (push_drop) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful.
  // When full, a simultaneous pop reads the old head before this write lands.
  always_ff @(posedge clk) begin
    if (!reset && !cin_clr && push_ok) begin
      mem_q[wr_ptr_q] <= value;
    end
  end

  logic [BUS_W-1:0] bus_val;

  always_comb begin
    bus_val = ((SIGN_EXT != 0) && out_q[DATA_W-1]) ? '1 : '0;
    bus_val[DATA_W-1:0] = out_q;
  end

  assign bus = cin_write ? bus_val : {BUS_W{1'bz}};

  assign cin_done     = done_q;
  assign cin_valid    = valid;
  assign cin_full     = full;
  assign cin_overflow = ovf_q;
  assign cin_count    = count_q;

endmodule
